// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - double-buffered 8-digit 7-segment scan driver; optional blink under SEG_BLINK_EN
module seg_scan_driver #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic        ready,
  output logic [7:0]  os_ENS,
  output logic [7:0]  os_COM,
  output logic        frame_start
`ifdef SEG_BLINK_EN
  ,
  input  logic [7:0]  blink_mask
`endif
);

  localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic        pending_q, pending_d;
  logic [31:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [7:0]  act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [7:0]  com_q, com_d, ens_q, ens_d;
  logic        fs_q, fs_d;
  logic        slot_last, frame_last;
  logic [3:0]  code_sel;
  logic        blank_digit;
  logic [7:0]  com_onehot;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b0000001;
      4'hB: glyph = 7'b1100111;
      4'hC: glyph = 7'b0011111;
      4'hD: glyph = 7'b0111100;
      4'hE: glyph = 7'b0001110;
      default: glyph = 7'b0000000;
    endcase
  endfunction

`ifdef SEG_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] fc_q, fc_d;
  logic            blink_on_q, blink_on_d;

  always_comb begin
    fc_d       = fc_q;
    blink_on_d = blink_on_q;
    if (frame_last) begin
      if (fc_q == FC_LAST) begin
        fc_d       = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      fc_q       <= '0;
      blink_on_q <= 1'b1;
    end else begin
      fc_q       <= fc_d;
      blink_on_q <= blink_on_d;
    end
  end

  assign blank_digit = ~blink_on_q & blink_mask[idx_q];
`else
  logic unused_blink_frames;
  assign unused_blink_frames = ^BLINK_FRAMES;
  assign blank_digit         = 1'b0;
`endif

  assign slot_last  = (presc_q == PRESC_LAST);
  assign frame_last = slot_last && (idx_q == 3'd7);
  assign code_sel   = act_dig_q[{idx_q, 2'b00} +: 4];
  assign com_onehot = 8'h80 >> idx_q;

  always_comb begin
    presc_d    = slot_last ? 16'd0 : presc_q + 16'd1;
    idx_d      = slot_last ? idx_q + 3'd1 : idx_q;
    pending_d  = pending_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    // load needs pending=0 and transfer needs pending=1, so they never collide
    if (load && !pending_q) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
      pending_d  = 1'b1;
    end else if (frame_last && pending_q) begin
      act_dig_d = pend_dig_q;
      act_dp_d  = pend_dp_q;
      pending_d = 1'b0;
    end

    // first cycle of every slot is blanked to stop ghosting between digits
    if (presc_q == 16'd0) begin
      com_d = 8'hFF;
      ens_d = 8'h00;
    end else begin
      com_d = ~com_onehot;
      ens_d = blank_digit ? 8'h00 : {glyph(code_sel), act_dp_q[idx_q]};
    end
    fs_d = (presc_q == 16'd0) && (idx_q == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      act_dig_q  <= 32'hFFFF_FFFF;
      act_dp_q   <= '0;
      pend_dig_q <= 32'hFFFF_FFFF;
      pend_dp_q  <= '0;
      com_q      <= 8'hFF;
      ens_q      <= 8'h00;
      fs_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      act_dig_q  <= act_dig_d;
      act_dp_q   <= act_dp_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      com_q      <= com_d;
      ens_q      <= ens_d;
      fs_q       <= fs_d;
    end
  end

  assign ready       = ~pending_q;
  assign os_COM      = com_q;
  assign os_ENS      = ens_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed vector bench for seg_scan_driver (SCAN_DIV=4)
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        nRST;
  logic [31:0] digits_in;
  logic [7:0]  dp_in;
  logic        load;
  logic        ready;
  logic [7:0]  os_ENS;
  logic [7:0]  os_COM;
  logic        frame_start;
`ifdef SEG_BLINK_EN
  logic [7:0]  blink_mask;
`endif

  int n_vec = 0;
  int n_err = 0;
  int k     = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .load       (load),
    .ready      (ready),
    .os_ENS     (os_ENS),
    .os_COM     (os_COM),
    .frame_start(frame_start)
`ifdef SEG_BLINK_EN
    ,
    .blink_mask (blink_mask)
`endif
  );

  typedef struct {
    int          k;
    logic        ld;
    logic [31:0] dg;
    logic [7:0]  dp;
    logic [7:0]  com;
    logic [7:0]  ens;
    logic        rdy;
    logic        fs;
  } vec_t;

  vec_t tv[18];

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic chk(input string name, input int at, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d actual=%h required=%h", name, at, act, exp);
    end
  endtask

  task automatic chk_all(input logic [7:0] com, input logic [7:0] ens, input logic rdy, input logic fs);
    chk("os_COM", k, os_COM, com);
    chk("os_ENS", k, os_ENS, ens);
    chk("ready", k, {7'd0, ready}, {7'd0, rdy});
    chk("frame_start", k, {7'd0, frame_start}, {7'd0, fs});
  endtask

  // Blank display: after tick k, outputs reflect scan state s = k-1
  task automatic scan_check(input int n);
    for (int j = 0; j < n; j++) begin
      int s, p, i;
      logic [7:0] oh, ec;
      tick();
      s  = k - 1;
      p  = s % 4;
      i  = (s / 4) % 8;
      oh = 8'h80 >> i;
      ec = (p == 0) ? 8'hFF : ~oh;
      chk_all(ec, 8'h00, 1'b1, (s % 32) == 0);
    end
  endtask

  task automatic run_to(input int kk);
    while (k < kk) begin
      tick();
      load = 1'b0;
    end
  endtask

  initial begin
    tv[0]  = '{40,  1'b1, 32'h7654_3210, 8'h01, 8'hBF, 8'h00, 1'b1, 1'b0};
    tv[1]  = '{41,  1'b1, 32'hAAAA_AAAA, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
    tv[2]  = '{42,  1'b0, 32'h0,         8'h00, 8'hDF, 8'h00, 1'b0, 1'b0};
    tv[3]  = '{63,  1'b0, 32'h0,         8'h00, 8'hFE, 8'h00, 1'b0, 1'b0};
    tv[4]  = '{64,  1'b0, 32'h0,         8'h00, 8'hFE, 8'h00, 1'b1, 1'b0};
    tv[5]  = '{65,  1'b0, 32'h0,         8'h00, 8'hFF, 8'h00, 1'b1, 1'b1};
    tv[6]  = '{66,  1'b0, 32'h0,         8'h00, 8'h7F, 8'hFD, 1'b1, 1'b0};
    tv[7]  = '{70,  1'b0, 32'h0,         8'h00, 8'hBF, 8'h60, 1'b1, 1'b0};
    tv[8]  = '{74,  1'b0, 32'h0,         8'h00, 8'hDF, 8'hDA, 1'b1, 1'b0};
    tv[9]  = '{94,  1'b0, 32'h0,         8'h00, 8'hFE, 8'hE0, 1'b1, 1'b0};
    tv[10] = '{97,  1'b1, 32'h8888_8888, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1};
    tv[11] = '{98,  1'b0, 32'h0,         8'h00, 8'h7F, 8'hFD, 1'b0, 1'b0};
    tv[12] = '{127, 1'b1, 32'h1111_1111, 8'hFF, 8'hFE, 8'hE0, 1'b0, 1'b0};
    tv[13] = '{128, 1'b0, 32'h0,         8'h00, 8'hFE, 8'hE0, 1'b1, 1'b0};
    tv[14] = '{129, 1'b0, 32'h0,         8'h00, 8'hFF, 8'h00, 1'b1, 1'b1};
    tv[15] = '{130, 1'b0, 32'h0,         8'h00, 8'h7F, 8'hFE, 1'b1, 1'b0};
    tv[16] = '{160, 1'b0, 32'h0,         8'h00, 8'hFE, 8'hFE, 1'b1, 1'b0};
    tv[17] = '{162, 1'b1, 32'h9999_9999, 8'hFF, 8'h7F, 8'hFE, 1'b1, 1'b0};

    nRST      = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    dp_in     = '0;
`ifdef SEG_BLINK_EN
    blink_mask = 8'h00;
`endif
    tick(); tick(); tick();
    chk_all(8'hFF, 8'h00, 1'b1, 1'b0);
    nRST = 1'b1;
    k    = 0;
    scan_check(40);

    for (int v = 0; v < 18; v++) begin
      run_to(tv[v].k);
      chk_all(tv[v].com, tv[v].ens, tv[v].rdy, tv[v].fs);
      load      = tv[v].ld;
      digits_in = tv[v].dg;
      dp_in     = tv[v].dp;
    end

    tick();
    load = 1'b0;
    chk("ready_after_load", k, {7'd0, ready}, 8'h00);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    chk_all(8'hFF, 8'h00, 1'b1, 1'b0);
    k = 0;
    scan_check(40);

`ifdef SEG_BLINK_EN
    nRST = 1'b0;
    tick();
    nRST       = 1'b1;
    k          = 0;
    blink_mask = 8'h80;
    load       = 1'b1;
    digits_in  = 32'h8888_8888;
    dp_in      = 8'h00;
    run_to(62);  chk("blink_on_f1",  k, os_ENS, 8'hFE); chk("blink_com", k, os_COM, 8'hFE);
    run_to(90);  chk("blink_d6",     k, os_ENS, 8'hFE); chk("blink_com6", k, os_COM, 8'hFD);
    run_to(94);  chk("blink_off_f2", k, os_ENS, 8'h00); chk("blink_com", k, os_COM, 8'hFE);
    run_to(126); chk("blink_off_f3", k, os_ENS, 8'h00);
    run_to(158); chk("blink_on_f4",  k, os_ENS, 8'hFE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
